// File: rtl/mig_mem_loader.sv
// mig_mem_loader: streams a block of words into the shared SRAM, hands the
// bus to the majority decoder, waits for its pass to finish, then pulses done.
// All outputs are decoded from the state register or come straight from
// registers, so in_valid never reaches the SRAM controls combinationally.
module mig_mem_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] load_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address_MIG,
  output logic [DATA_W-1:0] wr_data,
  output logic              drive_bus,
  output logic              CS,
  output logic              WE,
  output logic              OE,
  output logic              enable,
  output logic [ADDR_W-1:0] address_start,
  input  logic              exec_done,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        state_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [ADDR_W-1:0] base_p0;
  logic [ADDR_W-1:0] cnt_p0;
  logic [DATA_W-1:0] data_p0;

  // Address step; natural overflow gives the 31 -> 0 wrap of the SRAM.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  // Job sequencing: load words one handshake at a time, turn the bus around,
  // then let the decoder run until it reports a finished pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= S_IDLE;
    end else begin
      case (state_p0)
        S_IDLE:    if (start) state_p0 <= S_WAIT;
        S_WAIT:    if (in_valid) state_p0 <= S_WRITE;
        S_WRITE:   state_p0 <= (cnt_p0 == '0) ? S_RELEASE : S_WAIT;
        S_RELEASE: state_p0 <= S_RUN;
        S_RUN:     if (exec_done) state_p0 <= S_DONE;
        S_DONE:    state_p0 <= S_IDLE;
        default:   state_p0 <= S_IDLE;
      endcase
    end
  end

  // Job parameters, running address/count and the word being written.
  // The last write leaves the address on the final word rather than stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p0 <= '0;
      base_p0 <= '0;
      cnt_p0  <= '0;
      data_p0 <= '0;
    end else begin
      case (state_p0)
        S_IDLE: begin
          if (start) begin
            base_p0 <= base_addr;
            addr_p0 <= base_addr;
            cnt_p0  <= load_count;
          end
        end
        S_WAIT: begin
          if (in_valid) data_p0 <= in_data;
        end
        S_WRITE: begin
          if (cnt_p0 != '0) begin
            cnt_p0  <= cnt_p0 - ADDR_W'(1);
            addr_p0 <= addr_inc(addr_p0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (state_p0 == S_WAIT);
  assign CS            = (state_p0 == S_WRITE);
  assign WE            = (state_p0 == S_WRITE);
  assign drive_bus     = (state_p0 == S_WRITE);
  assign OE            = 1'b0;
  assign enable        = (state_p0 == S_RUN);
  assign done          = (state_p0 == S_DONE);
  assign busy          = (state_p0 != S_IDLE);
  assign address_MIG   = addr_p0;
  assign address_start = base_p0;
  assign wr_data       = data_p0;

endmodule

// File: tb/tb_mig_mem_loader.sv
// Bench for mig_mem_loader: per-cycle comparison against a job-level model,
// plus literal expectations for the directed scenarios.
module tb_mig_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  base_addr;
  logic [4:0]  load_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [4:0]  address_MIG;
  logic [31:0] wr_data;
  logic        drive_bus;
  logic        CS;
  logic        WE;
  logic        OE;
  logic        enable;
  logic [4:0]  address_start;
  logic        exec_done;
  logic        busy;
  logic        done;

  mig_mem_loader #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .load_count(load_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .address_MIG(address_MIG), .wr_data(wr_data),
    .drive_bus(drive_bus), .CS(CS), .WE(WE), .OE(OE), .enable(enable),
    .address_start(address_start), .exec_done(exec_done), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- job-level reference model ----------------
  // ph: 0 idle, 1 awaiting a word, 2 writing, 3 turnaround, 4 decoder run, 5 done
  int          ph = 0;
  int          m_n = 0;
  logic [4:0]  m_base = '0;
  logic [4:0]  m_am = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] acc_q[$];
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_lat = -1;
  bit          lat_ok = 0;
  int          job_k = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; m_n = 0; m_base = '0; m_am = '0; m_wd = '0;
      acc_q.delete();
    end else begin
      cyc++;
      case (ph)
        0: if (start) begin
             ph = 1; m_base = base_addr; m_n = int'(load_count) + 1;
             acc_q.delete(); start_cyc = cyc;
           end
        1: if (in_valid) begin
             acc_q.push_back(in_data); m_wd = in_data; ph = 2;
           end
        2: ph = (acc_q.size() == m_n) ? 3 : 1;
        3: ph = 4;
        4: if (exec_done) ph = 5;
        default: ph = 0;
      endcase
      case (ph)
        1: m_am = 5'((int'(m_base) + acc_q.size()) % 32);
        2: m_am = 5'((int'(m_base) + acc_q.size() - 1) % 32);
        3, 4, 5: m_am = 5'((int'(m_base) + m_n - 1) % 32);
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle compare and logs ----------------
  logic [4:0]  wlog_a[$];
  logic [31:0] wlog_d[$];
  logic [4:0]  enlog[$];
  logic        en_prev = 1'b0;

  always @(negedge clk) begin
    chk("in_ready", in_ready, ph == 1);
    chk("CS", CS, ph == 2);
    chk("WE", WE, ph == 2);
    chk("OE", OE, 1'b0);
    chk("drive_bus", drive_bus, ph == 2);
    chk("enable", enable, ph == 4);
    chk("busy", busy, ph != 0);
    chk("done", done, ph == 5);
    chk("address_MIG", address_MIG, m_am);
    chk("address_start", address_start, m_base);
    chk("wr_data", wr_data, m_wd);
    if (CS && WE) begin
      wlog_a.push_back(address_MIG);
      wlog_d.push_back(wr_data);
    end
    if (enable && !en_prev) enlog.push_back(address_start);
    en_prev = enable;
    if (done && ph == 5 && !rst) begin
      last_lat = cyc - start_cyc;
      if (lat_ok) chk("latency", last_lat, 2 * m_n + 2 + job_k);
    end
  end

  // ---------------- stimulus ----------------
  bit          fixed_mode = 0;
  logic [31:0] fixed_d[2];

  task automatic clear_logs();
    wlog_a.delete(); wlog_d.delete(); enlog.delete();
  endtask

  task automatic run_job(input logic [4:0] b, input logic [4:0] lc, input bit hold_v,
                         input bit hold_s, input int k, input bit spur, input int stall);
    int  guard;
    int  fidx;
    bit  acc;
    start = 1'b1; base_addr = b; load_count = lc;
    lat_ok = hold_v && (stall == 0);
    job_k = k;
    guard = 0; fidx = 0;
    do begin
      if (guard < stall) in_valid = 1'b0;
      else in_valid = hold_v ? 1'b1 : ($urandom_range(2) != 0);
      in_data = fixed_mode ? ((fidx < 2) ? fixed_d[fidx] : 32'h0) : $urandom;
      exec_done = spur && ($urandom_range(3) == 0);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) fidx++;
      if (!hold_s) start = 1'b0;
      guard++;
      if (stall > 0 && guard == stall) begin
        chk("stall_in_ready", in_ready, 1'b1);
        chk("stall_CS", CS, 1'b0);
      end
    end while (!enable && guard < 400);
    if (!enable) chk("enable_timeout", 1'b0, 1'b1);
    exec_done = 1'b0; in_valid = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
    exec_done = 1'b1;
    @(posedge clk); #1;
    exec_done = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int wsave;
    logic [31:0] mask;
    rst = 1'b1; start = 0; base_addr = 0; load_count = 0;
    in_valid = 0; in_data = 0; exec_done = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", address_MIG, 5'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // two-word load at 3 with known data
    clear_logs();
    fixed_mode = 1; fixed_d[0] = 32'h6800_0000; fixed_d[1] = 32'h0000_0003;
    run_job(5'd3, 5'd1, 1, 0, 2, 0, 0);
    fixed_mode = 0;
    chk("d36_nwr", wlog_a.size(), 2);
    if (wlog_a.size() == 2) begin
      chk("d36_a0", wlog_a[0], 5'd3);
      chk("d36_d0", wlog_d[0], 32'h6800_0000);
      chk("d36_a1", wlog_a[1], 5'd4);
      chk("d36_d1", wlog_d[1], 32'h0000_0003);
    end
    chk("d36_nen", enlog.size(), 1);
    if (enlog.size() == 1) chk("d36_astart", enlog[0], 5'd3);
    chk("d36_latency", last_lat, 8);

    // upstream stall of 5 cycles
    clear_logs();
    run_job(5'd7, 5'd2, 1, 0, 3, 0, 5);
    chk("d37_nwr", wlog_a.size(), 3);

    // address wrap
    clear_logs();
    run_job(5'd31, 5'd1, 1, 0, 1, 0, 0);
    chk("d38_nwr", wlog_a.size(), 2);
    if (wlog_a.size() == 2) begin
      chk("d38_a0", wlog_a[0], 5'd31);
      chk("d38_a1", wlog_a[1], 5'd0);
    end

    // exec_done noise while loading, real pulse 4 cycles into the run
    clear_logs();
    run_job(5'd10, 5'd3, 0, 0, 4, 1, 0);
    chk("d39_busy", busy, 1'b0);
    chk("d39_nwr", wlog_a.size(), 4);

    // reset during the second of four writes
    clear_logs();
    start = 1; base_addr = 5'd0; load_count = 5'd3; in_valid = 1; in_data = $urandom;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    for (int g = 0; g < 40 && n < 2; g++) begin
      @(negedge clk);
      if (CS) n++;
    end
    chk("d40_reached_w2", n, 2);
    #1 rst = 1'b1;
    #1;
    chk("d40_CS", CS, 1'b0);
    chk("d40_WE", WE, 1'b0);
    chk("d40_drive", drive_bus, 1'b0);
    chk("d40_busy", busy, 1'b0);
    chk("d40_rdy", in_ready, 1'b0);
    chk("d40_addr", address_MIG, 5'd0);
    chk("d40_wd", wr_data, 32'd0);
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wsave = wlog_a.size();
    in_valid = 1;
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 0;
    chk("d40_no_write", wlog_a.size(), wsave);
    chk("d40_idle", busy, 1'b0);
    clear_logs();
    run_job(5'd9, 5'd0, 1, 0, 0, 0, 0);
    chk("d40_one_write", wlog_a.size(), 1);

    // 32-word load with start held through the job
    clear_logs();
    run_job(5'd5, 5'd31, 0, 1, 1, 0, 0);
    chk("d41_nwr", wlog_a.size(), 32);
    mask = '0;
    foreach (wlog_a[i]) mask[wlog_a[i]] = 1'b1;
    chk("d41_cover", mask, 32'hFFFF_FFFF);
    chk("d41_idle", busy, 1'b0);

    // randomized jobs
    for (int j = 0; j < 12; j++) begin
      run_job(5'($urandom), 5'($urandom_range(7)), 1'($urandom_range(1)), 1'b0,
              $urandom_range(5), 1'($urandom_range(1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
